// File: rtl/ascon_serial_loader.sv
// ascon_serial_loader: deserialises key/nonce/AD/data streams MSB first and issues
// edge-gated single-cycle start pulses to the Ascon core, tracking it until done.
module ascon_serial_loader #(
    parameter int K = 128,
    parameter int N = 128,
    parameter int L = 40,
    parameter int Y = 104,
    localparam int KN = (K > N) ? K : N,
    localparam int LY = (L > Y) ? L : Y,
    localparam int MAX = (KN > LY) ? KN : LY,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          shift_en,
    input  logic          key_si,
    input  logic          nonce_si,
    input  logic          ad_si,
    input  logic          data_si,
    input  logic          start_i,
    input  logic          decrypt_i,
    input  logic          clear_i,
    input  logic          core_done_i,
    output logic [K-1:0]  key_o,
    output logic [N-1:0]  nonce_o,
    output logic [L-1:0]  ad_o,
    output logic [Y-1:0]  data_o,
    output logic          decrypt_o,
    output logic          core_start_o,
    output logic          loaded_o,
    output logic          busy_o,
    output logic [CW-1:0] bit_cnt_o
);
    typedef enum logic [1:0] {LOAD, FULL, RUN, DONE} state_t;
    state_t state, state_n;
    logic start_q, start_edge, shift, armed;
    logic start_n, busy_n, loaded_n, decrypt_n;
    logic [CW-1:0] cnt_n;

    assign start_edge = start_i & ~start_q;
    assign shift = (state == LOAD) && shift_en && !clear_i;
    assign armed = (state == FULL) || (state == DONE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= LOAD;
            start_q      <= 1'b0;
            key_o        <= '0;
            nonce_o      <= '0;
            ad_o         <= '0;
            data_o       <= '0;
            decrypt_o    <= 1'b0;
            core_start_o <= 1'b0;
            loaded_o     <= 1'b0;
            busy_o       <= 1'b0;
            bit_cnt_o    <= '0;
        end else begin
            state        <= state_n;
            start_q      <= start_i;
            key_o        <= (shift && bit_cnt_o < CW'(K)) ? {key_o[K-2:0], key_si} : key_o;
            nonce_o      <= (shift && bit_cnt_o < CW'(N)) ? {nonce_o[N-2:0], nonce_si} : nonce_o;
            ad_o         <= (shift && bit_cnt_o < CW'(L)) ? {ad_o[L-2:0], ad_si} : ad_o;
            data_o       <= (shift && bit_cnt_o < CW'(Y)) ? {data_o[Y-2:0], data_si} : data_o;
            decrypt_o    <= decrypt_n;
            core_start_o <= start_n;
            loaded_o     <= loaded_n;
            busy_o       <= busy_n;
            bit_cnt_o    <= cnt_n;
        end
    end

    // done arriving alongside the start pulse belongs to no operation yet
    always_comb begin
        state_n = clear_i ? LOAD :
                  (shift && bit_cnt_o == CW'(MAX - 1)) ? FULL :
                  (armed && start_edge) ? RUN :
                  (state == RUN && core_done_i && !core_start_o) ? DONE : state;
    end

    always_comb begin
        start_n   = armed && start_edge && !clear_i;
        decrypt_n = start_n ? decrypt_i : decrypt_o;
        busy_n    = (state_n == RUN);
        cnt_n     = clear_i ? '0 : shift ? bit_cnt_o + 1'b1 : bit_cnt_o;
        loaded_n  = (cnt_n == CW'(MAX));
    end
endmodule

// File: tb/tb_ascon_serial_loader.sv
// tb_ascon_serial_loader: directed vectors for load, start gating, clear and reset behaviour.
module tb_ascon_serial_loader;
    logic clk = 0, rstb = 0, shift_en = 0;
    logic key_si = 0, nonce_si = 0, ad_si = 0, data_si = 0;
    logic start_i = 0, decrypt_i = 0, clear_i = 0, core_done_i = 0;
    logic [127:0] key_o, nonce_o;
    logic [39:0] ad_o;
    logic [103:0] data_o;
    logic decrypt_o, core_start_o, loaded_o, busy_o;
    logic [7:0] bit_cnt_o;
    int n_cmp = 0, n_bad = 0, pulses = 0, p0;
    logic [7:0] c0;

    localparam logic [127:0] KEY = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
    localparam logic [39:0] AD = 40'h4153434f4e;
    localparam logic [103:0] PT = 104'h6173636f6e2d756e6963617373;
    localparam logic [103:0] CT = 104'h18490112f8d5867a830748390b;

    ascon_serial_loader dut (
        .clk(clk), .rstb(rstb), .shift_en(shift_en), .key_si(key_si), .nonce_si(nonce_si),
        .ad_si(ad_si), .data_si(data_si), .start_i(start_i), .decrypt_i(decrypt_i),
        .clear_i(clear_i), .core_done_i(core_done_i), .key_o(key_o), .nonce_o(nonce_o),
        .ad_o(ad_o), .data_o(data_o), .decrypt_o(decrypt_o), .core_start_o(core_start_o),
        .loaded_o(loaded_o), .busy_o(busy_o), .bit_cnt_o(bit_cnt_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (core_start_o) pulses++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1;
        step();
        clear_i = 0;
    endtask

    task automatic load(input logic [103:0] d, input int stp, input int pause);
        for (int i = 0; i < 128; i++) begin
            if (i == pause) begin
                shift_en = 0;
                c0 = bit_cnt_o;
                repeat (10) step();
                chk("freeze_cnt", bit_cnt_o, c0);
            end
            shift_en = 1;
            key_si = KEY[127-i];
            nonce_si = NONCE[127-i];
            ad_si = (i < 40) ? AD[39-i] : 1'($urandom);
            data_si = (i < 104) ? d[103-i] : 1'($urandom);
            start_i = (i == stp);
            if (i == 127) chk("not_loaded_early", loaded_o, 0);
            step();
        end
        shift_en = 0;
        start_i = 0;
    endtask

    task automatic chk_ops(input string tag, input logic [103:0] d);
        chk({tag, "_key"}, key_o, KEY);
        chk({tag, "_nonce"}, nonce_o, NONCE);
        chk({tag, "_ad"}, ad_o, AD);
        chk({tag, "_data"}, data_o, d);
    endtask

    initial begin
        #12;
        chk("rst_key", key_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cnt", bit_cnt_o, 0);
        chk("rst_flags", {decrypt_o, core_start_o, loaded_o, busy_o}, 0);
        @(posedge clk); #1 rstb = 1;
        // 1: encrypt load
        load(PT, -1, -1);
        chk("t1_loaded", loaded_o, 1);
        chk("t1_cnt", bit_cnt_o, 128);
        chk_ops("t1", PT);
        // 2: start held for five cycles
        p0 = pulses;
        start_i = 1;
        decrypt_i = 0;
        step();
        chk("t2_pulse", core_start_o, 1);
        chk("t2_busy", busy_o, 1);
        chk("t2_dec", decrypt_o, 0);
        repeat (4) step();
        chk("t2_one_pulse", 128'(pulses - p0), 1);
        start_i = 0;
        repeat (14) step();
        chk("t2_busy_hold", busy_o, 1);
        core_done_i = 1;
        step();
        core_done_i = 0;
        chk("t2_done_busy", busy_o, 0);
        chk("t2_done_loaded", loaded_o, 1);
        // 3: start during load is ignored
        do_clear();
        chk("t3_clr_cnt", bit_cnt_o, 0);
        chk("t3_clr_loaded", loaded_o, 0);
        p0 = pulses;
        decrypt_i = 1;
        load(PT, 60, -1);
        step();
        chk("t3_no_pulse", 128'(pulses - p0), 0);
        chk("t3_dec", decrypt_o, 0);
        chk("t3_loaded", loaded_o, 1);
        // 4: decrypt reload, done during pulse ignored
        do_clear();
        load(CT, -1, -1);
        chk_ops("t4", CT);
        p0 = pulses;
        start_i = 1;
        step();
        chk("t4_pulse", core_start_o, 1);
        chk("t4_dec", decrypt_o, 1);
        core_done_i = 1;
        step();
        core_done_i = 0;
        start_i = 0;
        chk("t4_early_done", busy_o, 1);
        core_done_i = 1;
        step();
        core_done_i = 0;
        chk("t4_done", busy_o, 0);
        chk("t4_one_pulse", 128'(pulses - p0), 1);
        // 5: pause mid-load, then clear beats start
        do_clear();
        load(PT, -1, 50);
        chk_ops("t5", PT);
        chk("t5_cnt", bit_cnt_o, 128);
        p0 = pulses;
        clear_i = 1;
        start_i = 1;
        step();
        clear_i = 0;
        chk("t5_no_pulse", core_start_o, 0);
        chk("t5_cnt0", bit_cnt_o, 0);
        chk("t5_loaded0", loaded_o, 0);
        step();
        start_i = 0;
        chk("t5_no_late_pulse", 128'(pulses - p0), 0);
        // 6: reset during run
        load(PT, -1, -1);
        decrypt_i = 0;
        start_i = 1;
        step();
        start_i = 0;
        step();
        chk("t6_busy", busy_o, 1);
        rstb = 0;
        #1;
        chk("t6_rst_ops", {key_o[15:0], nonce_o[15:0], ad_o[15:0], data_o[15:0]}, 0);
        chk("t6_rst_flags", {decrypt_o, core_start_o, loaded_o, busy_o, bit_cnt_o}, 0);
        @(posedge clk); #1 rstb = 1;
        p0 = pulses;
        core_done_i = 1;
        step();
        core_done_i = 0;
        start_i = 1;
        step();
        start_i = 0;
        step();
        chk("t6_no_pulse", 128'(pulses - p0), 0);
        chk("t6_idle", {busy_o, loaded_o, bit_cnt_o}, 0);
        load(CT, -1, -1);
        start_i = 1;
        step();
        start_i = 0;
        core_done_i = 1;
        step();
        step();
        core_done_i = 0;
        chk("t6_done", busy_o, 0);
        decrypt_i = 1;
        start_i = 1;
        step();
        start_i = 0;
        chk("t6_restart", core_start_o, 1);
        chk("t6_restart_dec", decrypt_o, 1);
        chk("t6_restart_busy", busy_o, 1);
        chk_ops("t6", CT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ascon_serial_loader.md
Name: ascon_serial_loader

Overview:
Input stage directly upstream of the Ascon AEAD core in the Caravel user project. Deserialises the four pad-level serial streams (key, nonce, associated data, input data) into parallel operand registers, MSB first. Gates the asynchronous-from-host start strobe into a single-cycle core start pulse, latches the encrypt/decrypt mode, and tracks the core until it reports done.

Parameters:
K, 128, key width in bits
N, 128, nonce width in bits
L, 40, associated-data width in bits
Y, 104, plaintext/ciphertext width in bits
MAX, max(K,N,L,Y) = 128, number of load cycles; local, derived
CW, clog2(MAX+1) = 8, bit counter width; local, derived

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
shift_en  in  1  one serial bit per field is valid this cycle; the top level ties it to 1 for pad use
key_si  in  1  serial key bit
nonce_si  in  1  serial nonce bit
ad_si  in  1  serial associated-data bit
data_si  in  1  serial plaintext/ciphertext bit
start_i  in  1  start request as a level; the block acts on its rising edge
decrypt_i  in  1  mode: 0 encrypt, 1 decrypt
clear_i  in  1  synchronous restart of the load sequence
core_done_i  in  1  core finished; may be a pulse or a level
key_o  out  K  parallel key
nonce_o  out  N  parallel nonce
ad_o  out  L  parallel associated data
data_o  out  Y  parallel input data
decrypt_o  out  1  mode latched at the accepted start
core_start_o  out  1  one-cycle start pulse to the core
loaded_o  out  1  all MAX bit slots captured
busy_o  out  1  core operation outstanding
bit_cnt_o  out  CW  bits captured so far

Behaviour:
- Reset (rstb=0, asynchronous):
  - state=LOAD; cnt=0; all operand registers 0; decrypt_o=0; core_start_o=0; loaded_o=0; busy_o=0; start edge register=0.
- Shifting (state LOAD and shift_en=1 only):
  - For each field of width W: if cnt<W then F <= {F[W-2:0], serial bit}; otherwise F holds.
  - The first bit received ends up in the field MSB.
  - cnt increments by 1 per shifting cycle.
  - On the shift where cnt==MAX-1: cnt becomes MAX, state becomes FULL, loaded_o=1 from the next cycle.
- Freezing: outside LOAD, or with shift_en=0, operands and cnt hold. Serial inputs are ignored.
- Start edge: start_q is a register of start_i. edge = start_i & ~start_q, evaluated in every state.
- FULL: on edge, latch decrypt_o <= decrypt_i, assert core_start_o for exactly one cycle (the cycle after the edge), go to RUN. busy_o=1 from that same cycle.
- LOAD: an edge is ignored. It is not queued and decrypt_o does not change.
- RUN: further edges are ignored. When core_done_i=1, go to DONE and busy_o=0 from the next cycle. core_done_i in the same cycle as the start pulse is ignored; done is only honoured from the cycle after the pulse.
- DONE: operands and decrypt_o hold. A new edge re-issues core_start_o with the same operands, re-latches decrypt, and goes to RUN.
- clear_i=1 in any state:
  - next state LOAD, cnt=0, loaded_o=0, busy_o=0, core_start_o=0.
  - Operand registers are not zeroed; they are overwritten by the next load.
  - clear has priority over a simultaneous edge, shift, or core_done.
- Holding start_i high across many cycles produces one pulse only.
- Reset asserted mid-RUN returns to the reset state immediately. No pulse is generated after reset release until a fresh load and edge occur.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Encrypt load: reset, 128 cycles shifting MSB-first KEY=6d4f8bbf60ec05a07b201d4e5b2119ac, NONCE=05885e606e1271b8d47a74c7b297a318, AD=4153434f4e (bits 40..127 random), PT=6173636f6e2d756e6963617373 (bits 104..127 random).
   -> loaded_o=1 at cycle 128, bit_cnt_o=128, key_o/nonce_o/ad_o/data_o equal the values exactly; random tail bits do not alter AD or data.
2. With start_i high for 5 cycles and decrypt_i=0 after test 1.
   -> exactly one core_start_o pulse, one cycle after the edge; decrypt_o=0; busy_o=1 until core_done_i is driven high at cycle 20, then busy_o=0 and state DONE.
3. Start pulse at cycle 60 of the load, decrypt_i=1.
   -> no core_start_o; decrypt_o stays 0; load completes normally at cycle 128.
4. Decrypt: clear_i, reload with CT=18490112f8d5867a830748390b, start with decrypt_i=1.
   -> data_o=CT, decrypt_o=1, single pulse.
5. clear_i and start edge in the same cycle while FULL.
   -> no pulse, bit_cnt_o=0, loaded_o=0. Separately: shift_en=0 for 10 cycles mid-load -> bit_cnt_o frozen and final operands unchanged.
6. rstb low for 1 cycle during RUN.
   -> all outputs at reset values immediately; core_done_i afterwards has no effect; DONE-state re-start re-issues a pulse with the operands unchanged.
